// File: rtl/fifo_video_out_pkg.sv
// Shared timing defaults, colour-bar table and FSM state type for fifo_video_out.
package video_pkg;
    localparam int unsigned DEF_H_ACTIVE = 80;
    localparam int unsigned DEF_H_FP     = 4;
    localparam int unsigned DEF_H_SYNC   = 8;
    localparam int unsigned DEF_H_BP     = 8;
    localparam int unsigned DEF_V_ACTIVE = 60;
    localparam int unsigned DEF_V_FP     = 1;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 2;
    localparam logic        DEF_SYNC_POL = 1'b0;
    localparam int unsigned RGB_W        = 24;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    // White, yellow, cyan, green, magenta, red, blue, black.
    localparam logic [RGB_W-1:0] BAR_COLOURS [8] = '{
        24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
    };
endpackage

// File: rtl/fifo_video_out_if.sv
// Bundle for fifo_video_out: FIFO read side, raster/pixel outputs and status flags.
// The test_mode input exists only when FIFO_VIDEO_OUT_TEST_PATTERN_EN is defined.
interface fifo_video_out_if;
    import video_pkg::*;

    logic             start;
    logic             fifo_empty;
    logic [RGB_W-1:0] fifo_dout;
    logic             fifo_ren;
    logic             hsync;
    logic             vsync;
    logic             de;
    logic [RGB_W-1:0] rgb;
    logic             frame_done;
    logic             underflow;
`ifdef FIFO_VIDEO_OUT_TEST_PATTERN_EN
    logic             test_mode;
`endif

    // Video block side: pops the FIFO and drives the panel.
    modport master (
`ifdef FIFO_VIDEO_OUT_TEST_PATTERN_EN
        input  test_mode,
`endif
        input  start, fifo_empty, fifo_dout,
        output fifo_ren, hsync, vsync, de, rgb, frame_done, underflow
    );

    // Environment side: FIFO owner and display sink.
    modport slave (
`ifdef FIFO_VIDEO_OUT_TEST_PATTERN_EN
        output test_mode,
`endif
        output start, fifo_empty, fifo_dout,
        input  fifo_ren, hsync, vsync, de, rgb, frame_done, underflow
    );
endinterface

// File: rtl/fifo_video_out_timing_gen.sv
// Raster counters, IDLE/RUN FSM and active/sync/last-pixel decode for fifo_video_out.
// Frame-edge and h_cnt outputs exist only with FIFO_VIDEO_OUT_TEST_PATTERN_EN.
module video_timing_gen
    import video_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP
) (
    input  logic clk,
    input  logic rst,
    input  logic i_start,
    input  logic i_fifo_empty,
    output logic o_run,
    output logic o_active,
    output logic o_hsync_on,
    output logic o_vsync_on,
    output logic o_last
`ifdef FIFO_VIDEO_OUT_TEST_PATTERN_EN
    ,
    output logic o_frame_edge,
    output logic [$clog2(H_ACTIVE+H_FP+H_SYNC+H_BP)-1:0] o_h_cnt
`endif
);
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [HW-1:0] r_h_cnt;
    logic [VW-1:0] r_v_cnt;
    logic          w_h_wrap;
    logic          w_v_wrap;
    logic          w_frame_wrap;

    assign w_h_wrap     = (32'(r_h_cnt) == H_TOTAL - 1);
    assign w_v_wrap     = (32'(r_v_cnt) == V_TOTAL - 1);
    assign w_frame_wrap = w_h_wrap && w_v_wrap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Leaving RUN is only allowed on the frame wrap, so frames are never cut short.
    always_comb begin
        w_state_nxt = r_state;
        o_run       = 1'b0;
        unique case (r_state)
            IDLE: if (i_start && !i_fifo_empty) w_state_nxt = RUN;
            RUN: begin
                o_run = 1'b1;
                if (w_frame_wrap && !i_start) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (r_state != RUN) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_h_wrap) begin
            r_h_cnt <= '0;
            r_v_cnt <= w_v_wrap ? '0 : r_v_cnt + 1'b1;
        end else begin
            r_h_cnt <= r_h_cnt + 1'b1;
        end
    end

    assign o_active   = o_run && (32'(r_h_cnt) < H_ACTIVE) && (32'(r_v_cnt) < V_ACTIVE);
    assign o_hsync_on = (32'(r_h_cnt) >= H_ACTIVE + H_FP) && (32'(r_h_cnt) < H_ACTIVE + H_FP + H_SYNC);
    assign o_vsync_on = (32'(r_v_cnt) >= V_ACTIVE + V_FP) && (32'(r_v_cnt) < V_ACTIVE + V_FP + V_SYNC);
    assign o_last     = o_active && (32'(r_h_cnt) == H_ACTIVE - 1) && (32'(r_v_cnt) == V_ACTIVE - 1);

`ifdef FIFO_VIDEO_OUT_TEST_PATTERN_EN
    assign o_frame_edge = !o_run || w_frame_wrap;
    assign o_h_cnt      = r_h_cnt;
`endif
endmodule

// File: rtl/fifo_video_out.sv
// Pixel FIFO to raster video: pops one word per active pixel, two-stage aligned outputs.
// FIFO_VIDEO_OUT_TEST_PATTERN_EN adds test_mode with an 8-bar colour pattern.
module fifo_video_out
    import video_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter logic        SYNC_POL = DEF_SYNC_POL
) (
    input  logic              clk,
    input  logic              rst,
    fifo_video_out_if.master  bus
);
    logic             w_run;
    logic             w_active;
    logic             w_hs_on;
    logic             w_vs_on;
    logic             w_last;
    logic             w_tm;
    logic             w_ren;
    logic             w_starve;
    logic [RGB_W-1:0] w_rgb_nxt;

    logic r_ren_q, r_active_q, r_hs_q, r_vs_q, r_last_q, r_starve_q;

`ifdef FIFO_VIDEO_OUT_TEST_PATTERN_EN
    localparam int unsigned HW    = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam int unsigned BAR_W = H_ACTIVE / 8;

    logic          w_frame_edge;
    logic [HW-1:0] w_h_cnt;
    logic [2:0]    w_bar;
    logic          r_test_mode;
    logic          r_tp_q;
    logic [2:0]    r_bar_q;
`endif

    video_timing_gen #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
    ) u_timing (
        .clk          (clk),
        .rst          (rst),
        .i_start      (bus.start),
        .i_fifo_empty (bus.fifo_empty),
        .o_run        (w_run),
        .o_active     (w_active),
        .o_hsync_on   (w_hs_on),
        .o_vsync_on   (w_vs_on),
        .o_last       (w_last)
`ifdef FIFO_VIDEO_OUT_TEST_PATTERN_EN
        ,
        .o_frame_edge (w_frame_edge),
        .o_h_cnt      (w_h_cnt)
`endif
    );

`ifdef FIFO_VIDEO_OUT_TEST_PATTERN_EN
    // test_mode only changes between frames so a frame is never half pattern.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)               r_test_mode <= 1'b0;
        else if (w_frame_edge) r_test_mode <= bus.test_mode;
    end
    assign w_tm  = r_test_mode;
    assign w_bar = 3'(32'(w_h_cnt) / BAR_W);
`else
    assign w_tm  = 1'b0;
`endif

    // w_active already includes the RUN state.
    assign w_ren        = w_active && !bus.fifo_empty && !w_tm;
    assign w_starve     = w_active &&  bus.fifo_empty && !w_tm;
    assign bus.fifo_ren = w_ren;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ren_q    <= 1'b0;
            r_active_q <= 1'b0;
            r_hs_q     <= 1'b0;
            r_vs_q     <= 1'b0;
            r_last_q   <= 1'b0;
            r_starve_q <= 1'b0;
        end else begin
            r_ren_q    <= w_ren;
            r_active_q <= w_active;
            r_hs_q     <= w_hs_on;
            r_vs_q     <= w_vs_on;
            r_last_q   <= w_last;
            r_starve_q <= w_starve;
        end
    end

`ifdef FIFO_VIDEO_OUT_TEST_PATTERN_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tp_q  <= 1'b0;
            r_bar_q <= '0;
        end else begin
            r_tp_q  <= w_tm;
            r_bar_q <= w_bar;
        end
    end
`endif

    always_comb begin
        w_rgb_nxt = '0;
        if (r_ren_q) w_rgb_nxt = bus.fifo_dout;
`ifdef FIFO_VIDEO_OUT_TEST_PATTERN_EN
        if (r_tp_q && r_active_q) w_rgb_nxt = BAR_COLOURS[r_bar_q];
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.rgb        <= '0;
            bus.de         <= 1'b0;
            bus.hsync      <= ~SYNC_POL;
            bus.vsync      <= ~SYNC_POL;
            bus.frame_done <= 1'b0;
            bus.underflow  <= 1'b0;
        end else begin
            bus.rgb        <= w_rgb_nxt;
            bus.de         <= r_active_q;
            bus.hsync      <= r_hs_q ? SYNC_POL : ~SYNC_POL;
            bus.vsync      <= r_vs_q ? SYNC_POL : ~SYNC_POL;
            bus.frame_done <= r_last_q;
            bus.underflow  <= bus.underflow | r_starve_q;
        end
    end
endmodule

// File: tb/tb_fifo_video_out.sv
// Self-checking bench for fifo_video_out: behavioural FIFO, frame-level reference model,
// scoreboard monitor on de, and raster timing checks relative to the first pixel.
`timescale 1ns/1ps
module tb_fifo_video_out;
    import video_pkg::*;

    localparam int unsigned H_TOT     = 100;
    localparam int unsigned V_TOT     = 65;
    localparam int unsigned H_ACT     = 80;
    localparam int unsigned V_ACT     = 60;
    localparam int unsigned HS_START  = 84;
    localparam int unsigned HS_END    = 92;
    localparam int unsigned VS_START  = 61;
    localparam int unsigned VS_END    = 63;
    localparam int unsigned NPIX      = H_ACT * V_ACT;
    localparam int unsigned FRAME_CYC = H_TOT * V_TOT;

    typedef struct {
        logic [23:0] rgb;
        logic        fd;
        logic        uf;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fifo_video_out_if bus();

    fifo_video_out #(
        .H_ACTIVE (80), .H_FP (4), .H_SYNC (8), .H_BP (8),
        .V_ACTIVE (60), .V_FP (1), .V_SYNC (2), .V_BP (2),
        .SYNC_POL (1'b0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural FIFO: wr_cnt owned by stimulus, rd_cnt by the pop process.
    logic [23:0] mem [16384];
    int unsigned wr_cnt = 0;
    int unsigned rd_cnt = 0;
    assign bus.fifo_empty = (wr_cnt == rd_cnt);

    initial begin
        bus.fifo_dout = '0;
        forever begin
            @(posedge clk);
            if (bus.fifo_ren) begin
                bus.fifo_dout <= mem[14'(rd_cnt)];
                rd_cnt        <= rd_cnt + 1;
            end
        end
    end

    int n_tests = 0;
    int n_fail  = 0;
    exp_t sb_q[$];
    int unsigned m_rd = 0;
    bit          m_uf = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] bar_colour(input int unsigned b);
        logic r, g, bl;
        g  = (b < 4);
        r  = ((b % 4) < 2);
        bl = ((b % 2) == 0);
        return {{8{r}}, {8{g}}, {8{bl}}};
    endfunction

    task automatic load_word(input logic [23:0] v);
        mem[14'(wr_cnt)] = v;
        wr_cnt++;
    endtask

    // Expected pixels of one frame: next FIFO words while they last, then zeros with underflow.
    task automatic push_frame(input bit tmode);
        int unsigned avail;
        exp_t e;
        avail = wr_cnt - m_rd;
        for (int unsigned p = 0; p < NPIX; p++) begin
            if (tmode) begin
                e.rgb = bar_colour((p % H_ACT) / (H_ACT / 8));
            end else if (p < avail) begin
                e.rgb = mem[14'(m_rd + p)];
            end else begin
                e.rgb = 24'h0;
                m_uf  = 1'b1;
            end
            e.uf = m_uf;
            e.fd = (p == NPIX - 1);
            sb_q.push_back(e);
        end
        if (!tmode) m_rd += (avail < NPIX) ? avail : NPIX;
    endtask

    // Scoreboard monitor.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("ren_while_empty", 32'(bus.fifo_ren & bus.fifo_empty), 0);
                chk("frame_done_without_de", 32'(bus.frame_done & ~bus.de), 0);
                if (bus.de) begin
                    if (sb_q.size() == 0) begin
                        chk("pixel_expected_in_queue", 32'(sb_q.size()), 1);
                    end else begin
                        e = sb_q.pop_front();
                        chk("pixel", {6'b0, bus.rgb, bus.frame_done, bus.underflow},
                                     {6'b0, e.rgb, e.fd, e.uf});
                    end
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_fifo_ren"},   32'(bus.fifo_ren),   0);
        chk({tag, "_de"},         32'(bus.de),         0);
        chk({tag, "_rgb"},        32'(bus.rgb),        0);
        chk({tag, "_frame_done"}, 32'(bus.frame_done), 0);
        chk({tag, "_underflow"},  32'(bus.underflow),  0);
        chk({tag, "_hsync"},      32'(bus.hsync),      1);
        chk({tag, "_vsync"},      32'(bus.vsync),      1);
    endtask

    // Called on a negedge right after the frame was kicked off; ends one raster later.
    task automatic run_frame(input int unsigned drop_k, input bit tmode, input int unsigned extra);
        int unsigned lat, errs, ren_cnt, h, v;
        bit exp_de, exp_hs, exp_vs;
        lat = 0; errs = 0; ren_cnt = 0;
        while (!bus.de && lat < 20) begin
            @(negedge clk);
            lat++;
            if (bus.fifo_ren && tmode) ren_cnt++;
        end
        chk("start_to_first_pixel_latency", lat, 3);
        for (int unsigned k = 0; k < FRAME_CYC; k++) begin
            h = k % H_TOT;
            v = (k / H_TOT) % V_TOT;
            exp_de = (h < H_ACT) && (v < V_ACT);
            exp_hs = !((h >= HS_START) && (h < HS_END));
            exp_vs = !((v >= VS_START) && (v < VS_END));
            if (bus.de !== exp_de || bus.hsync !== exp_hs || bus.vsync !== exp_vs) errs++;
            if (tmode && bus.fifo_ren) ren_cnt++;
            if (k == drop_k) bus.start = 1'b0;
            if (k == 6000) for (int unsigned i = 0; i < extra; i++) load_word(24'($urandom));
            @(negedge clk);
        end
        chk("raster_timing_error_cycles", errs, 0);
        if (tmode) chk("test_mode_pops", ren_cnt, 0);
    endtask

    task automatic idle_check(input string tag);
        int unsigned busy;
        busy = 0;
        repeat (5) @(negedge clk);
        repeat (200) begin
            if (bus.fifo_ren || bus.de) busy++;
            @(negedge clk);
        end
        chk({tag, "_idle_activity"}, busy, 0);
    endtask

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
`ifdef FIFO_VIDEO_OUT_TEST_PATTERN_EN
        bus.test_mode = 1'b0;
`endif
        #1;
        check_reset_outputs("reset");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Full frame of index values; FIFO empties exactly on the last pixel.
        for (int unsigned i = 0; i < NPIX; i++) load_word(24'(i));
        push_frame(1'b0);
        bus.start = 1'b1;
        run_frame($urandom_range(500, 5500), 1'b0, 100);
        idle_check("after_full");
        chk("pops_full_frame", rd_cnt, NPIX);
        chk("underflow_after_full", 32'(bus.underflow), 0);

        // Only 100 words: underflow from pixel 100 onward; restart begins at pixel 0.
        push_frame(1'b0);
        bus.start = 1'b1;
        run_frame($urandom_range(500, 5500), 1'b0, 0);
        idle_check("after_short");
        chk("pops_short_frame", rd_cnt, NPIX + 100);
        chk("underflow_sticky", 32'(bus.underflow), 1);

        // Reset in the middle of a frame.
        for (int unsigned i = 0; i < NPIX; i++) load_word(24'($urandom));
        push_frame(1'b0);
        bus.start = 1'b1;
        repeat ($urandom_range(200, 900)) @(negedge clk);
        #1 rst = 1'b1;
        #1 check_reset_outputs("midframe_reset");
        sb_q.delete();
        wr_cnt = rd_cnt;
        m_rd   = rd_cnt;
        m_uf   = 1'b0;
        for (int unsigned i = 0; i < NPIX; i++) load_word(24'($urandom));
        push_frame(1'b0);
        @(negedge clk);
        rst = 1'b0;
        run_frame($urandom_range(500, 5500), 1'b0, 0);
        idle_check("after_reset_frame");

`ifdef FIFO_VIDEO_OUT_TEST_PATTERN_EN
        for (int unsigned i = 0; i < 10; i++) load_word(24'($urandom));
        push_frame(1'b1);
        bus.test_mode = 1'b1;
        bus.start     = 1'b1;
        run_frame($urandom_range(500, 5500), 1'b1, 0);
        bus.test_mode = 1'b0;
        idle_check("after_pattern");
        chk("fifo_untouched_by_pattern", wr_cnt - rd_cnt, 10);
`endif

        chk("scoreboard_drained", 32'(sb_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/fifo_video_out.md
Name: fifo_video_out

Overview:
- Downstream consumer of the pixel FIFO that the ROM display stage fills with 24-bit RGB words (4800 words = one 80x60 frame).
- Generates raster timing (hsync, vsync, data-enable).
- Pops one FIFO word per active pixel and drives registered RGB to the panel/VGA pins.
- Flags underflow and reports end-of-frame so the upstream stage can restart its ROM walk.

Parameters:
- H_ACTIVE, 80, active pixels per line
- H_FP, 4, horizontal front porch (clocks)
- H_SYNC, 8, hsync pulse width
- H_BP, 8, horizontal back porch
- V_ACTIVE, 60, active lines per frame
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 2, vertical back porch (lines)
- SYNC_POL, 0, sync active level (0 = active-low)

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- start  in  1  level; enables raster generation
- fifo_empty  in  1  FIFO empty flag
- fifo_dout  in  24  FIFO read data, valid one cycle after fifo_ren
- fifo_ren  out  1  FIFO read enable
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- de  out  1  data enable, aligned with rgb
- rgb  out  24  pixel {R[23:16],G[15:8],B[7:0]}
- frame_done  out  1  one-cycle pulse coincident with last active pixel on rgb
- underflow  out  1  sticky; set on any active pixel with FIFO empty

Interface: one clock, clk; reset rst is asynchronous, active-high.

Behaviour:
- Reset values:
  - fifo_ren=0, de=0, rgb=0, frame_done=0, underflow=0
  - hsync and vsync at the inactive level (~SYNC_POL)
  - state IDLE, h_cnt=0, v_cnt=0
- FSM IDLE:
  - Counters held at 0; no reads.
  - Go to RUN when start=1 and fifo_empty=0.
- FSM RUN:
  - h_cnt runs 0..H_TOTAL-1 (H_TOTAL = sum of H params) and wraps to 0.
  - v_cnt increments when h_cnt wraps; v_cnt runs 0..V_TOTAL-1 and wraps.
  - If start=0 when h_cnt and v_cnt both wrap (frame boundary), return to IDLE. Frames are never truncated.
- Region decode:
  - active = (h_cnt < H_ACTIVE) and (v_cnt < V_ACTIVE).
  - hsync asserted for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - vsync asserted for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
- Read rule: fifo_ren = RUN and active and !fifo_empty. This term is combinational from the counters and fifo_empty.
- Pipeline:
  - Stage 1 registers ren_q, active_q, sync_q, last_q, where last = active and h_cnt=H_ACTIVE-1 and v_cnt=V_ACTIVE-1.
  - Stage 2 registers rgb = ren_q ? fifo_dout : 24'h0, plus de, hsync, vsync and frame_done from the stage-1 copies.
  - Latency counter to pins = 2 clocks; all outputs mutually aligned.
- Underflow:
  - Active pixel with fifo_empty=1: no pop, rgb = 0 for that pixel, timing continues.
  - underflow is set in stage 2 and stays set until reset.
- Boundaries:
  - The last-pixel-of-line pop and the first-pixel-of-next-line pop are separated by blanking; no back-to-back constraint.
  - The FIFO going empty exactly on the last active pixel of a frame still pulses frame_done.
- Reset mid-frame: all outputs return to reset values immediately (asynchronously); FIFO contents are not flushed by this block.
- Width rules: h_cnt and v_cnt use clog2 of H_TOTAL and V_TOTAL; all compares are unsigned.

Optional Feature:
- Macro: FIFO_VIDEO_OUT_TEST_PATTERN_EN.
- When defined:
  - Adds input port test_mode (1 bit).
  - test_mode=1: fifo_ren is forced 0 and rgb shows 8 vertical colour bars, each H_ACTIVE/8 pixels wide. Bar order: white, yellow, cyan, green, magenta, red, blue, black (24'hFFFFFF..24'h000000).
  - underflow is not set while test_mode=1.
  - test_mode is sampled only at frame boundaries.
- When undefined: no port and no pattern logic; behaviour exactly as above.

Decomposition:
- Shared package (video_pkg):
  - Default timing constants.
  - Colour-bar constant array.
  - State enum {IDLE, RUN}.
- One natural sub-module: video_timing_gen. It contains the counters, the active/hsync/vsync/last decode and the FSM. The top adds the FIFO read, the pipeline and the flags.

Test Plan:
- FIFO preloaded with 4800 words (value = index), start=1:
  - 4800 pops, rgb sequence 0..4799 with de=1 only on those cycles.
  - One frame_done pulse aligned with word 4799; underflow=0.
- Timing check with default params (H_TOTAL=100, V_TOTAL=65):
  - hsync low for exactly 8 clocks starting at h_cnt=84.
  - vsync low for 2 lines starting at line 61.
  - de high 80 clocks per line on lines 0..59.
- FIFO holding only 100 words:
  - pixels 100.. of line 1 and beyond output 24'h0.
  - underflow rises two clocks after the first empty active pixel and remains 1.
- start deasserted mid-frame:
  - Frame completes to v_cnt wrap, then IDLE with fifo_ren=0.
  - Next start resumes with pixel 0 on line 0.
- rst pulsed mid-line:
  - All outputs go to reset values within the same cycle.
  - After release with start=1 and a non-empty FIFO, the first pop occurs at h_cnt=0, v_cnt=0.
- With the macro defined, test_mode=1:
  - Pixels 0..9 are 24'hFFFFFF and 70..79 are 24'h000000.
  - fifo_ren stays 0 for the whole frame.
